ifu_fetch_ctrl: RTL and testbench

- Sequences one fetch block at a time from the FTQ through the I-cache to the IFU predecode stage.
- Accepts a fetch request (start PC and FTQ index) and issues a block-aligned I-cache read.
- Captures the returned line and presents PredictWidth instruction slots, with a validity mask derived from the start offset.
- Handles redirect flushes in every state, including discarding an in-flight I-cache response.

---
 rtl/ifu_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch controller: takes one FTQ fetch block at a time, issues an aligned
// I-cache read and hands the returned line with a slot mask to predecode.
module ifu_fetch_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned PredictWidth  = 4,
    parameter int unsigned BLOCK_BYTES   = 16,
    parameter int unsigned FTQ_IDX_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          ftq_req_valid,
    output logic                          ftq_req_ready,
    input  logic [XLEN-1:0]               ftq_req_pc,
    input  logic [FTQ_IDX_WIDTH-1:0]      ftq_req_idx,
    output logic                          icache_req_valid,
    input  logic                          icache_req_ready,
    output logic [XLEN-1:0]               icache_req_addr,
    input  logic                          icache_resp_valid,
    input  logic [BLOCK_BYTES*8-1:0]      icache_resp_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PredictWidth*32-1:0]    out_insts,
    output logic [PredictWidth-1:0]       out_mask,
    output logic [((PredictWidth > 1) ? $clog2(PredictWidth) : 1)-1:0] out_first_slot,
    output logic [XLEN-1:0]               out_pc,
    output logic [FTQ_IDX_WIDTH-1:0]      out_ftq_idx,
    output logic                          busy
);

    localparam int unsigned DATA_WIDTH = BLOCK_BYTES * 8;
    localparam int unsigned INST_W     = PredictWidth * 32;
    localparam int unsigned OFF_W      = $clog2(BLOCK_BYTES);
    localparam int unsigned SLOT_W     = (PredictWidth > 1) ? $clog2(PredictWidth) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [XLEN-1:0]            r_pc;
    logic [FTQ_IDX_WIDTH-1:0]   r_idx;
    logic                       w_accept;
    logic                       w_load;
    logic                       w_req_hs;
    logic [SLOT_W-1:0]          w_off;
    logic [PredictWidth-1:0]    w_mask;
    logic [XLEN-1:0]            w_addr;

    assign ftq_req_ready = (r_state == S_IDLE) && !flush;
    assign w_accept      = ftq_req_ready && ftq_req_valid;
    assign w_req_hs      = icache_req_valid && icache_req_ready;
    assign w_load        = (r_state == S_WAIT) && icache_resp_valid && !flush;
    assign w_addr        = {ftq_req_pc[XLEN-1:OFF_W], OFF_W'(0)};
    assign w_off         = SLOT_W'(r_pc[OFF_W-1:2]);

    // Slots below the start offset belong to an earlier fetch block
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < PredictWidth; i++) begin
            w_mask[i] = (i >= 32'(w_off));
        end
    end

    // Next-state logic; flush dominates, an outstanding read is always drained
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_REQ;
            end
            S_REQ: begin
                if (flush)         w_next = w_req_hs ? S_DRAIN : S_IDLE;
                else if (w_req_hs) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (flush)                  w_next = icache_resp_valid ? S_IDLE : S_DRAIN;
                else if (icache_resp_valid) w_next = S_OUT;
            end
            S_OUT: begin
                if (flush || out_ready) w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (icache_resp_valid) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and registered outputs, all derived from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_pc             <= '0;
            r_idx            <= '0;
            icache_req_valid <= 1'b0;
            icache_req_addr  <= '0;
            out_valid        <= 1'b0;
            out_insts        <= '0;
            out_mask         <= '0;
            out_first_slot   <= '0;
            out_pc           <= '0;
            out_ftq_idx      <= '0;
            busy             <= 1'b0;
        end else begin
            r_state          <= w_next;
            icache_req_valid <= (w_next == S_REQ);
            out_valid        <= (w_next == S_OUT);
            busy             <= (w_next != S_IDLE);
            if (w_accept) begin
                r_pc            <= ftq_req_pc;
                r_idx           <= ftq_req_idx;
                icache_req_addr <= w_addr;
            end
            if (w_load) begin
                out_insts      <= INST_W'(icache_resp_data[DATA_WIDTH-1:0]);
                out_mask       <= w_mask;
                out_first_slot <= w_off;
                out_pc         <= r_pc;
                out_ftq_idx    <= r_idx;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: aligned/unaligned fetch, backpressure,
// flush corner cases and reset during output.
module tb_ifu_fetch_ctrl;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          ftq_req_valid;
    logic          ftq_req_ready;
    logic [31:0]   ftq_req_pc;
    logic [5:0]    ftq_req_idx;
    logic          icache_req_valid;
    logic          icache_req_ready;
    logic [31:0]   icache_req_addr;
    logic          icache_resp_valid;
    logic [127:0]  icache_resp_data;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_insts;
    logic [3:0]    out_mask;
    logic [1:0]    out_first_slot;
    logic [31:0]   out_pc;
    logic [5:0]    out_ftq_idx;
    logic          busy;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] LINE_A = 128'h00000193_00000113_00000093_00000013;
    localparam logic [127:0] LINE_B = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    ifu_fetch_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .ftq_req_valid    (ftq_req_valid),
        .ftq_req_ready    (ftq_req_ready),
        .ftq_req_pc       (ftq_req_pc),
        .ftq_req_idx      (ftq_req_idx),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_req_addr  (icache_req_addr),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_data (icache_resp_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_insts        (out_insts),
        .out_mask         (out_mask),
        .out_first_slot   (out_first_slot),
        .out_pc           (out_pc),
        .out_ftq_idx      (out_ftq_idx),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ftq_req_valid = 1'b0; ftq_req_pc = '0; ftq_req_idx = '0;
        icache_req_ready = 1'b0; icache_resp_valid = 1'b0; icache_resp_data = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_req_valid", 128'(icache_req_valid), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_insts", out_insts, 128'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 128'(ftq_req_ready), 128'd1);

        // aligned fetch
        ftq_req_valid = 1'b1; ftq_req_pc = 32'h8000_0010; ftq_req_idx = 6'd5; icache_req_ready = 1'b1;
        tick();
        ftq_req_valid = 1'b0;
        chk("al_req_valid", 128'(icache_req_valid), 128'd1);
        chk("al_addr", 128'(icache_req_addr), 128'h8000_0010);
        chk("al_busy", 128'(busy), 128'd1);
        chk("al_ftq_ready", 128'(ftq_req_ready), 128'd0);
        tick();
        chk("al_wait_req", 128'(icache_req_valid), 128'd0);
        chk("al_wait_out", 128'(out_valid), 128'd0);
        icache_resp_valid = 1'b1; icache_resp_data = LINE_A;
        tick();
        icache_resp_valid = 1'b0; icache_resp_data = '0;
        chk("al_out_valid", 128'(out_valid), 128'd1);
        chk("al_insts", out_insts, LINE_A);
        chk("al_mask", 128'(out_mask), 128'b1111);
        chk("al_first", 128'(out_first_slot), 128'd0);
        chk("al_pc", 128'(out_pc), 128'h8000_0010);
        chk("al_idx", 128'(out_ftq_idx), 128'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("al_done_valid", 128'(out_valid), 128'd0);
        chk("al_done_busy", 128'(busy), 128'd0);

        // unaligned fetch
        ftq_req_valid = 1'b1; ftq_req_pc = 32'h8000_0018; ftq_req_idx = 6'd9;
        tick();
        ftq_req_valid = 1'b0;
        chk("un_addr", 128'(icache_req_addr), 128'h8000_0010);
        tick();
        icache_resp_valid = 1'b1; icache_resp_data = LINE_B;
        tick();
        icache_resp_valid = 1'b0;
        chk("un_out_valid", 128'(out_valid), 128'd1);
        chk("un_mask", 128'(out_mask), 128'b1100);
        chk("un_first", 128'(out_first_slot), 128'd2);
        chk("un_pc", 128'(out_pc), 128'h8000_0018);
        chk("un_insts", out_insts, LINE_B);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // backpressure on both sides
        icache_req_ready = 1'b0;
        ftq_req_valid = 1'b1; ftq_req_pc = 32'h8000_0024; ftq_req_idx = 6'd12;
        tick();
        ftq_req_valid = 1'b0; ftq_req_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", 128'(icache_req_valid), 128'd1);
            chk("bp_addr", 128'(icache_req_addr), 128'h8000_0020);
            tick();
        end
        icache_req_ready = 1'b1;
        chk("bp_req_valid_hs", 128'(icache_req_valid), 128'd1);
        tick();
        icache_resp_valid = 1'b1; icache_resp_data = LINE_A;
        tick();
        icache_resp_valid = 1'b0; icache_resp_data = LINE_B;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_insts", out_insts, LINE_A);
            chk("bp_mask", 128'(out_mask), 128'b1110);
            chk("bp_ftq_ready", 128'(ftq_req_ready), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_ready", 128'(ftq_req_ready), 128'd1);

        // flush in WAIT, stale response 4 cycles later, new request pending
        ftq_req_valid = 1'b1; ftq_req_pc = 32'h8000_0030; ftq_req_idx = 6'd1;
        tick();
        ftq_req_valid = 1'b0;
        tick();
        flush = 1'b1; ftq_req_valid = 1'b1; ftq_req_pc = 32'h8000_0044; ftq_req_idx = 6'd7;
        chk("fw_ready_flush", 128'(ftq_req_ready), 128'd0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fw_drain_busy", 128'(busy), 128'd1);
            chk("fw_drain_ready", 128'(ftq_req_ready), 128'd0);
            chk("fw_drain_req", 128'(icache_req_valid), 128'd0);
            tick();
        end
        icache_resp_valid = 1'b1; icache_resp_data = LINE_B;
        tick();
        icache_resp_valid = 1'b0;
        chk("fw_idle_out", 128'(out_valid), 128'd0);
        chk("fw_idle_busy", 128'(busy), 128'd0);
        chk("fw_idle_ready", 128'(ftq_req_ready), 128'd1);
        tick();
        ftq_req_valid = 1'b0;
        chk("fw_new_req", 128'(icache_req_valid), 128'd1);
        chk("fw_new_addr", 128'(icache_req_addr), 128'h8000_0040);
        tick();

        // flush together with response in WAIT
        flush = 1'b1; icache_resp_valid = 1'b1; icache_resp_data = LINE_A;
        tick();
        flush = 1'b0; icache_resp_valid = 1'b0;
        chk("fr_out", 128'(out_valid), 128'd0);
        chk("fr_busy", 128'(busy), 128'd0);
        tick();
        chk("fr_out_later", 128'(out_valid), 128'd0);

        // flush together with REQ handshake
        ftq_req_valid = 1'b1; ftq_req_pc = 32'h8000_0050; ftq_req_idx = 6'd3;
        tick();
        ftq_req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fh_busy", 128'(busy), 128'd1);
        chk("fh_req", 128'(icache_req_valid), 128'd0);
        chk("fh_ready", 128'(ftq_req_ready), 128'd0);
        icache_resp_valid = 1'b1;
        tick();
        icache_resp_valid = 1'b0;
        chk("fh_idle_busy", 128'(busy), 128'd0);
        chk("fh_idle_out", 128'(out_valid), 128'd0);

        // reset while holding a block in OUT
        ftq_req_valid = 1'b1; ftq_req_pc = 32'h8000_0060; ftq_req_idx = 6'd33;
        tick();
        ftq_req_valid = 1'b0;
        tick();
        icache_resp_valid = 1'b1; icache_resp_data = LINE_B;
        tick();
        icache_resp_valid = 1'b0;
        chk("rs_pre_out", 128'(out_valid), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_out", 128'(out_valid), 128'd0);
        chk("rs_busy", 128'(busy), 128'd0);
        chk("rs_insts", out_insts, 128'd0);
        tick();
        rst_n = 1'b1;
        icache_resp_valid = 1'b1; icache_resp_data = LINE_A;
        tick();
        icache_resp_valid = 1'b0;
        chk("rs_stray_out", 128'(out_valid), 128'd0);
        chk("rs_stray_busy", 128'(busy), 128'd0);
        chk("rs_stray_insts", out_insts, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
